// File: rtl/interleaver_sym_ctrl.sv
// Symbol-timing controller for the bit-serial 802.11a transmit interleaver: paces coded bits into
// N_CBPS-bit symbols with swap gaps, appends a zero flush symbol and qualifies the serial output.
module interleaver_sym_ctrl #(
  parameter int N_CBPS   = 48,
  parameter int SWAP_CYC = 1,
  parameter int OUT_LAT  = 1,
  parameter int SYM_W    = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start,
  input  logic [SYM_W-1:0] num_sym,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             il_reset,
  output logic             il_bit,
  input  logic             il_out,
  output logic             out_bit,
  output logic             out_valid,
  output logic             out_sos,
  output logic             out_eof,
  output logic             busy,
  output logic             underrun,
  output logic             done
);

  localparam int BCW = (N_CBPS > 1) ? $clog2(N_CBPS) : 1;

  typedef enum logic [2:0] {
    IDLE, ALIGN, FEED, SWAP, FLUSH_FEED, FLUSH_SWAP, DRAIN
  } state_t;

  state_t           state_reg, state_next;
  logic [BCW-1:0]   bit_cnt_reg;
  logic [SYM_W-1:0] sym_cnt_reg, num_sym_reg;
  logic             feed_last, swap_last, drain_last;
  logic             mark_valid, mark_sos, mark_eof;
  logic [2:0]       mark_dly [OUT_LAT];

  // bit_cnt is shared by every timed phase; each phase restarts it from zero
  assign feed_last  = (bit_cnt_reg == BCW'(N_CBPS - 1));
  assign swap_last  = (bit_cnt_reg == BCW'(SWAP_CYC - 1));
  assign drain_last = (bit_cnt_reg == BCW'(OUT_LAT - 1));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:       if (start && num_sym != '0) state_next = ALIGN;
      ALIGN:      state_next = FEED;
      FEED:       if (feed_last) state_next = SWAP;
      SWAP:       if (swap_last) state_next = (sym_cnt_reg < num_sym_reg) ? FEED : FLUSH_FEED;
      FLUSH_FEED: if (feed_last) state_next = FLUSH_SWAP;
      FLUSH_SWAP: if (swap_last) state_next = DRAIN;
      DRAIN:      if (drain_last) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    il_reset   = 1'b0;
    il_bit     = 1'b0;
    busy       = (state_reg != IDLE);
    mark_valid = 1'b0;
    mark_eof   = 1'b0;
    case (state_reg)
      ALIGN: il_reset = 1'b1;
      FEED: begin
        in_ready   = 1'b1;
        il_bit     = in_valid & in_bit;
        // slot 0 only fills the interleaver; its output is still empty
        mark_valid = (sym_cnt_reg != '0);
      end
      FLUSH_FEED: begin
        mark_valid = 1'b1;
        mark_eof   = feed_last;
      end
      default: ;
    endcase
    mark_sos = mark_valid && (bit_cnt_reg == '0);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      bit_cnt_reg <= '0;
      sym_cnt_reg <= '0;
      num_sym_reg <= '0;
      underrun    <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: if (start) begin
          underrun    <= 1'b0;
          num_sym_reg <= num_sym;
          done        <= (num_sym == '0);
        end
        ALIGN: begin
          bit_cnt_reg <= '0;
          sym_cnt_reg <= '0;
        end
        FEED: begin
          if (!in_valid) underrun <= 1'b1;
          if (feed_last) begin
            bit_cnt_reg <= '0;
            sym_cnt_reg <= sym_cnt_reg + SYM_W'(1);
          end else begin
            bit_cnt_reg <= bit_cnt_reg + BCW'(1);
          end
        end
        FLUSH_FEED:       bit_cnt_reg <= feed_last ? '0 : bit_cnt_reg + BCW'(1);
        SWAP, FLUSH_SWAP: bit_cnt_reg <= swap_last ? '0 : bit_cnt_reg + BCW'(1);
        DRAIN: begin
          if (drain_last) begin
            bit_cnt_reg <= '0;
            done        <= 1'b1;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + BCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Slot marker tracks the interleaver's output register, then lines up with out_bit
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < OUT_LAT; i++) mark_dly[i] <= '0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      out_sos   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      mark_dly[0] <= {mark_valid, mark_sos, mark_eof};
      for (int i = 1; i < OUT_LAT; i++) mark_dly[i] <= mark_dly[i-1];
      out_bit <= il_out;
      {out_valid, out_sos, out_eof} <= mark_dly[OUT_LAT-1];
    end
  end

endmodule

// File: tb/tb_interleaver_sym_ctrl.sv
// Bench for interleaver_sym_ctrl: a stub BPSK interleaver plus a slot-arithmetic reference model
// predicting every control and output flag cycle by cycle.
module tb_interleaver_sym_ctrl;

  localparam int N  = 48;
  localparam int S  = 1;
  localparam int L  = 1;
  localparam int SW = 8;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          start = 1'b0;
  logic [SW-1:0] num_sym = '0;
  logic          in_bit = 1'b0;
  logic          in_valid = 1'b0;
  logic          il_out = 1'b0;
  logic          in_ready, il_reset, il_bit, out_bit, out_valid, out_sos, out_eof;
  logic          busy, underrun, done, any_out;
  bit            clk_en = 1'b0;

  int total = 0;
  int bad = 0;
  int last_lat = 0;

  logic data_q [256][N];

  interleaver_sym_ctrl #(.N_CBPS(N), .SWAP_CYC(S), .OUT_LAT(L), .SYM_W(SW)) dut (
    .Clock(Clock), .Reset(Reset), .start(start), .num_sym(num_sym),
    .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready),
    .il_reset(il_reset), .il_bit(il_bit), .il_out(il_out),
    .out_bit(out_bit), .out_valid(out_valid), .out_sos(out_sos), .out_eof(out_eof),
    .busy(busy), .underrun(underrun), .done(done)
  );

  always #5 if (clk_en) Clock = ~Clock;

  assign any_out = in_ready | il_reset | il_bit | out_bit | out_valid | out_sos |
                   out_eof | busy | underrun | done;

  // First 802.11a permutation (BPSK: second permutation is identity)
  function automatic int perm(input int k);
    return (N / 16) * (k % 16) + k / 16;
  endfunction

  function automatic int inv_perm(input int j);
    return 16 * (j % (N / 16)) + j / (N / 16);
  endfunction

  // Stub interleaver: double buffer, swaps in the first gap cycle, one output register
  logic il_wbuf [N];
  logic il_rbuf [N];
  int   il_cnt = 0;
  bit   il_act = 1'b0;

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      il_act <= 1'b0;
      il_cnt <= 0;
      il_out <= 1'b0;
      for (int i = 0; i < N; i++) begin
        il_wbuf[i] <= 1'b0;
        il_rbuf[i] <= 1'b0;
      end
    end else if (il_reset) begin
      il_act <= 1'b1;
      il_cnt <= 0;
    end else if (il_act) begin
      if (il_cnt % (N + S) < N) begin
        il_wbuf[perm(il_cnt % (N + S))] <= il_bit;
        il_out <= il_rbuf[il_cnt % (N + S)];
      end else if (il_cnt % (N + S) == N) begin
        for (int i = 0; i < N; i++) il_rbuf[i] <= il_wbuf[i];
      end
      il_cnt <= il_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One frame of n symbols, predicted from slot arithmetic. drop_sym/drop_bit force one
  // invalid slot, drop_pct adds random ones, busy_start_at pulses start mid-frame,
  // abort_at asserts Reset at that cycle (cycle 0 = ALIGN).
  task automatic run_frame(input int n, input bit alt_pat, input int drop_sym, input int drop_bit,
                           input int drop_pct, input int busy_start_at, input int abort_at);
    int c_done, first_done, slot, p, cf, so, po;
    bit data_slot, v, b, ov, under, aborted;
    c_done     = (n + 1) * (N + S) + L + 1;
    first_done = -1;
    under      = 1'b0;
    aborted    = 1'b0;
    start      = 1'b1;
    num_sym    = SW'(n);
    in_valid   = 1'($urandom);
    in_bit     = 1'($urandom);
    @(negedge Clock);
    chk("idle_before_start", busy, 1'b0);
    @(posedge Clock); #1;
    for (int c = 0; c <= c_done + 1; c++) begin
      slot      = (c >= 1) ? (c - 1) / (N + S) : -1;
      p         = (c >= 1) ? (c - 1) % (N + S) : -1;
      data_slot = (c >= 1) && (slot < n) && (p < N);
      b         = alt_pat ? 1'(p % 2) : 1'($urandom);
      v         = 1'b1;
      if (data_slot) begin
        if (slot == drop_sym && p == drop_bit) v = 1'b0;
        else if (int'($urandom_range(99)) < drop_pct) v = 1'b0;
      end else begin
        v = 1'($urandom);
      end
      in_valid = v;
      in_bit   = b;
      if (data_slot) data_q[slot][p] = v & b;
      start   = (c == busy_start_at);
      num_sym = (c == busy_start_at) ? '0 : SW'($urandom);
      if (c == abort_at) begin
        Reset = 1'b1; #1;
        chk("abort_quiet", any_out, 1'b0);
        repeat (3) begin
          @(negedge Clock);
          chk("abort_no_done", done | busy, 1'b0);
        end
        @(posedge Clock); #1;
        Reset = 1'b0;
        start = 1'b0;
        repeat (3) begin
          @(negedge Clock);
          chk("post_abort_quiet", any_out, 1'b0);
        end
        @(posedge Clock); #1;
        aborted = 1'b1;
        break;
      end
      @(negedge Clock);
      cf = c - (L + 1);
      so = (cf >= 1) ? (cf - 1) / (N + S) : -1;
      po = (cf >= 1) ? (cf - 1) % (N + S) : -1;
      ov = (so >= 1) && (so <= n) && (po < N);
      chk("il_reset", il_reset, c == 0);
      chk("in_ready", in_ready, data_slot);
      chk("il_bit", il_bit, data_slot ? (v & b) : 1'b0);
      chk("busy", busy, c < c_done);
      chk("done", done, c == c_done);
      chk("underrun", underrun, under);
      chk("out_valid", out_valid, ov);
      chk("out_sos", out_sos, ov && po == 0);
      chk("out_eof", out_eof, ov && so == n && po == N - 1);
      if (ov) chk("out_bit", out_bit, data_q[so - 1][inv_perm(po)]);
      if (done === 1'b1 && first_done < 0) first_done = c;
      if (data_slot && !v) under = 1'b1;
      @(posedge Clock); #1;
    end
    start = 1'b0;
    if (!aborted) begin
      last_lat = first_done + 1;
      chk_int("start_to_done", last_lat, 1 + (n + 1) * (N + S) + L + 1);
    end
    $display("frame n=%0d drop=%0d/%0d pct=%0d abort=%0d lat=%0d total=%0d bad=%0d",
             n, drop_sym, drop_bit, drop_pct, abort_at, last_lat, total, bad);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with the clock stopped, then idle after release
    #3;
    chk("reset_no_clock", any_out, 1'b0);
    clk_en = 1'b1;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    repeat (5) begin
      in_valid = 1'($urandom);
      in_bit   = 1'($urandom);
      @(negedge Clock);
      chk("idle_quiet", any_out, 1'b0);
      @(posedge Clock); #1;
    end

    run_frame(1, 1'b1, -1, -1, 0, -1, -1);
    run_frame(3, 1'b0, -1, -1, 0, 30, -1);
    chk_int("lat_n3", last_lat, 199);
    run_frame(2, 1'b0, 0, 10, 0, -1, -1);
    chk("underrun_held", underrun, 1'b1);

    // num_sym == 0 start: done next cycle, never busy, underrun cleared
    start = 1'b1;
    num_sym = '0;
    @(negedge Clock);
    chk("zero_start_under_old", underrun, 1'b1);
    chk("zero_start_busy0", busy, 1'b0);
    @(posedge Clock); #1;
    start = 1'b0;
    num_sym = SW'($urandom);
    @(negedge Clock);
    chk("zero_done", done, 1'b1);
    chk("zero_busy", busy, 1'b0);
    chk("zero_under_clr", underrun, 1'b0);
    chk("zero_no_align", il_reset | in_ready, 1'b0);
    @(posedge Clock); #1;
    @(negedge Clock);
    chk("zero_done_once", done | busy, 1'b0);
    @(posedge Clock); #1;
    $display("zero-symbol start total=%0d bad=%0d", total, bad);

    run_frame(4, 1'b0, -1, -1, 0, -1, 1 + (N + S) + 20);
    run_frame(2, 1'b0, -1, -1, 0, -1, -1);
    run_frame(5, 1'b0, -1, -1, 5, -1, -1);
    run_frame(255, 1'b0, -1, -1, 1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
